// File: rtl/regfile_param_pkg.sv
// Shared encodings for the parametrised register file and its bulk-clear engine.
package regfile_param_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/regfile_param_clear_fsm.sv
// Bulk-clear sequencer: sweeps every entry to zero, one per clock, and holds off
// external writes until the sweep and its completion cycle are over.
module rf_clear_fsm
   import regfile_param_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req_i,
   output logic              wr_ready_o,
   output logic              clr_busy_o,
   output logic              clr_done_o,
   output logic              clr_stb_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              wr_ready_q;
   logic              busy_q;
   logic              done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         wr_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_req_i) begin
                  state_q    <= CLEAR;
                  ptr_q      <= '0;
                  wr_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            CLEAR: begin
               // Terminal compare on DEPTH-1 so non-power-of-2 depths stop on time.
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == LAST_ADDR) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               wr_ready_q <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               ptr_q      <= '0;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               wr_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign wr_ready_o = wr_ready_q;
   assign clr_busy_o = busy_q;
   assign clr_done_o = done_q;
   assign clr_stb_o  = (state_q == CLEAR);
   assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file with optional hard-wired zero
// entry, write-to-read bypass and a sequential bulk-clear engine.
module regfile_param
   import regfile_param_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              clr_stb;
   logic [ADDR_W-1:0] clr_addr;
   logic              waddr_ok;
   logic              wr_commit;

   rf_clear_fsm #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_fsm (
      .clk        (clk),
      .rst        (rst),
      .clr_req_i  (clr_req),
      .wr_ready_o (wr_ready),
      .clr_busy_o (clr_busy),
      .clr_done_o (clr_done),
      .clr_stb_o  (clr_stb),
      .clr_addr_o (clr_addr)
   );

   assign waddr_ok  = ({1'b0, waddr} < DEPTH_L) && !((ZERO_REG != 0) && (waddr == '0));
   assign wr_commit = we && wr_ready && waddr_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clr_stb && (clr_addr == ADDR_W'(i))) begin
               mem_q[i] <= '0;
            end else if (wr_commit && (waddr == ADDR_W'(i))) begin
               mem_q[i] <= wdata;
            end
         end
      end
   end

   // Out-of-range addresses match no entry and fall through to zero.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (a == ADDR_W'(i)) begin
            v = mem_q[i];
         end
      end
      if ((ZERO_REG != 0) && (a == '0)) begin
         v = '0;
      end
      if ((BYPASS != 0) && wr_commit && (a == waddr)) begin
         v = wdata;
      end
      if (!rst) begin
         v = '0;
      end
      return v;
   endfunction

   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-read register file; next generation of the 32x32 regfile used by the single-cycle CPU datapath.
- Generalised in data width, depth and zero-register mode.
- Adds write-to-read bypass in place of the old read-blanking during writes.
- Adds a sequential bulk-clear engine (FSM + sweep counter) so software or the control unit can zero the file without a reset.

Parameters:
- DATA_W, 32, data width of every entry.
- ADDR_W, 5, address width of every port.
- DEPTH, 32, number of entries; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- ZERO_REG, 1, if 1, entry 0 always reads 0 and ignores writes.
- BYPASS, 1, if 1, an accepted write is forwarded combinationally to a matching read port in the same cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wr_ready  out  1  write-accept qualifier; a write commits only when we && wr_ready.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.
- clr_req  in  1  bulk-clear request; level, sampled each clock.
- clr_busy  out  1  high while the clear sequence is in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - all entries <= 0; FSM <= IDLE; sweep pointer <= 0.
  - clr_busy=0, clr_done=0, wr_ready=1.
  - Reads return 0 while reset is asserted.
- Write:
  - commits on the rising edge when we && wr_ready && waddr < DEPTH && !(ZERO_REG && waddr==0).
  - Otherwise the write is dropped silently, with no error flag.
- Read (latency 0, combinational):
  - raddr >= DEPTH -> 0.
  - ZERO_REG && raddr==0 -> 0.
  - BYPASS && write committing this cycle && raddr==waddr -> wdata.
  - Otherwise -> stored entry.
  - With BYPASS=0, same-cycle reads return the old value; the new value is visible the next cycle.
  - Both ports are evaluated independently; equal addresses on both ports are legal.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: wr_ready=1, clr_busy=0. clr_req=1 -> CLEAR, pointer <= 0.
  - CLEAR: wr_ready=0, clr_busy=1. Each cycle entry[pointer] <= 0, pointer++. Clearing entry DEPTH-1 -> DONE.
  - DONE: wr_ready=0, clr_busy=1, clr_done=1 for exactly one cycle -> IDLE.
  - Total: clr_req sampled at edge N; DONE in cycle N+DEPTH; wr_ready returns at edge N+DEPTH+1.
- clr_req in CLEAR or DONE is ignored. A clr_req still high on return to IDLE starts a new sweep, since it is level-sensitive.
- Simultaneous we and clr_req in IDLE: the write commits (wr_ready=1 that cycle); the sweep starts next cycle and zeroes it.
- Reads during CLEAR return stored contents: already-swept entries read 0, unswept entries keep old data. No bypass of clear writes.
- Reset mid-sweep aborts immediately to the reset state. No clr_done pulse.
- Pointer width is ADDR_W. Terminal compare is against DEPTH-1, not wrap-around, so a non-power-of-2 DEPTH terminates correctly.

Decomposition:
- Shared package/include holds the FSM state encoding constants: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2.
- One natural sub-module: rf_clear_fsm.
  - Contains the state register, sweep pointer, clr_busy/clr_done/wr_ready generation, and a clear-strobe/clear-address output.
  - The storage array, write decode and read muxes stay in regfile_param.

Test Plan:
- Reset then write sequence: write 0xDEADBEEF to r5, next cycle raddr1=5 -> rdata1=0xDEADBEEF. raddr2=6 -> 0.
- Zero register: ZERO_REG=1, write 0x12345678 to r0 -> rdata1(raddr1=0)=0. Repeat with ZERO_REG=0 -> 0x12345678.
- Bypass: write 0xA5A5A5A5 to r7 with raddr1=raddr2=7 in the same cycle -> both read 0xA5A5A5A5 that cycle (BYPASS=1). Old value with BYPASS=0.
- Bulk clear, DEPTH=32:
  - fill all entries with index+1, pulse clr_req.
  - clr_busy high for 33 cycles; clr_done single pulse in cycle 33; wr_ready=0 throughout.
  - a write to r3 mid-sweep is dropped; afterwards all reads return 0.
- Simultaneous events: we (r9=0x55) and clr_req in the same IDLE cycle -> write commits, then r9 reads 0 after clr_done.
- Out-of-range and reset mid-sweep:
  - DEPTH=20: write to r25 is ignored; raddr=25 -> 0.
  - assert rst at sweep cycle 10 -> clr_busy=0 immediately, no clr_done, all entries 0, wr_ready=1 after release.
